// File: rtl/tx_irq_moderator_if.sv
// ---------------------------------------------------------------------------
// tx_irq_moderator_if
//
// Purpose: bundles the pointer stream, host status and PCIe core interrupt
// handshake that the tx interrupt moderator consumes and drives.
//
// Signals:
//   hw_ptr_update       1   single-cycle pulse: hw_ptr advanced
//   hw_ptr              64  hardware producer pointer
//   sw_ptr              64  host consumer pointer (BAR write-back)
//   hst_rdy             1   host accepts interrupts; 0 freezes moderation
//   cfg_interrupt_n     1   interrupt request to PCIe core, active low
//   cfg_interrupt_rdy_n 1   PCIe core accept, active low
//
// Modports:
//   master  producer / host / PCIe core side (drives pointers and accept)
//   slave   moderator side (drives the interrupt request)
// ---------------------------------------------------------------------------
interface tx_irq_moderator_if;
    logic        hw_ptr_update;
    logic [63:0] hw_ptr;
    logic [63:0] sw_ptr;
    logic        hst_rdy;
    logic        cfg_interrupt_n;
    logic        cfg_interrupt_rdy_n;

    modport master (
        output hw_ptr_update,
        output hw_ptr,
        output sw_ptr,
        output hst_rdy,
        output cfg_interrupt_rdy_n,
        input  cfg_interrupt_n
    );

    modport slave (
        input  hw_ptr_update,
        input  hw_ptr,
        input  sw_ptr,
        input  hst_rdy,
        input  cfg_interrupt_rdy_n,
        output cfg_interrupt_n
    );
endinterface

// File: rtl/tx_irq_moderator.sv
// ---------------------------------------------------------------------------
// tx_irq_moderator
//
// Purpose: interrupt moderation behind the tx path. Coalesces hw_ptr updates
// either by event count (PKT_TH) or by a holdoff timer (HOLDOFF), then raises
// a legacy/MSI request towards the Virtex-5 PCIe core using the
// cfg_interrupt_n / cfg_interrupt_rdy_n handshake. After a granted interrupt
// further requests are masked until the host writes back sw_ptr.
//
// Ports:
//   clk          in   pcie_clk domain clock
//   rst_n        in   asynchronous reset, active low
//   bus          if   tx_irq_moderator_if.slave (pointers, hst_rdy, handshake)
//   irq_pending  out  1 whenever the moderator is not idle
//   irq_count    out  interrupts granted since reset, wraps at 2^32
//
// Optional feature (macro IRQ_LOCKOUT_TIMEOUT_EN):
//   defined   -> the timer is reloaded with LOCKOUT_TO when entering LOCKOUT;
//                if it expires while the host still has not written back
//                sw_ptr and the pointers still differ, the request is re-fired.
//   undefined -> LOCKOUT is left only on sw_ptr write-back; LOCKOUT_TO unused.
//
// Timing notes:
//   All outputs are registered. A request condition seen in cycle N shows up
//   as cfg_interrupt_n=0 in cycle N+1. The holdoff timer is loaded with
//   HOLDOFF and the request fires in the cycle the timer would count down to
//   zero, so the request appears HOLDOFF+1 cycles after the arming update
//   (counting the update cycle as cycle 0).
// ---------------------------------------------------------------------------
module tx_irq_moderator #(
    parameter int unsigned TW         = 16,
    parameter int unsigned HOLDOFF    = 1000,
    parameter int unsigned PKT_TH     = 8,
    parameter int unsigned CW         = 8,
    parameter int unsigned LOCKOUT_TO = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tx_irq_moderator_if.slave        bus,
    output logic                     irq_pending,
    output logic [31:0]              irq_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_REQ     = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [TW-1:0] HOLDOFF_LOAD = TW'(HOLDOFF);
    localparam logic [CW-1:0] EV_MAX       = {CW{1'b1}};

`ifdef IRQ_LOCKOUT_TIMEOUT_EN
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_TO);
`else
    // Keeps the parameter referenced in builds without the re-fire timeout.
    logic [TW-1:0] unused_lockout_to;
    assign unused_lockout_to = TW'(LOCKOUT_TO);
`endif

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t          state_reg,     state_next;
    logic [TW-1:0]   timer_reg,     timer_next;
    logic [CW-1:0]   evcnt_reg,     evcnt_next;
    logic [63:0]     sw_snap_reg,   sw_snap_next;
    logic [31:0]     irq_count_reg, irq_count_next;
    logic            ptr_neq_reg;
    logic            cfg_int_n_reg;
    logic            irq_pending_reg;

    // -----------------------------------------------------------------------
    // Per-cycle helper terms
    // -----------------------------------------------------------------------
    logic [CW-1:0]   evcnt_inc;     // event count including this cycle's update
    logic            th_hit;        // enough updates to force an interrupt
    logic            timer_exp;     // timer completes its count this cycle
    logic            sw_moved;      // host wrote back a new sw_ptr since grant

    always_comb begin
        evcnt_inc = evcnt_reg;
        if (bus.hw_ptr_update && (evcnt_reg != EV_MAX)) begin
            evcnt_inc = evcnt_reg + CW'(1);
        end
    end

    // Threshold uses the count including the current update so that the
    // PKT_TH-th update requests in the very next cycle.
    assign th_hit    = (32'(evcnt_inc) >= PKT_TH);
    // The timer is loaded with its full period; treating 1 (and 0, for a
    // zero period) as expiry makes the request land exactly one period after
    // loading once the registered output delay is included.
    assign timer_exp = (timer_reg <= TW'(1));
    assign sw_moved  = (bus.sw_ptr != sw_snap_reg);

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        evcnt_next     = evcnt_reg;
        sw_snap_next   = sw_snap_reg;
        irq_count_next = irq_count_reg;

        case (state_reg)
            ST_IDLE: begin
                // Updates are counted even while the host is not ready, so
                // a backlog builds up and arms as soon as hst_rdy returns.
                evcnt_next = evcnt_inc;
                if (bus.hst_rdy && (bus.hw_ptr_update || ptr_neq_reg)) begin
                    if (th_hit) begin
                        // Threshold already reached (PKT_TH=1 or a backlog
                        // collected while the host was not ready).
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_ARMED;
                        timer_next = HOLDOFF_LOAD;
                    end
                end
            end

            ST_ARMED: begin
                if (!ptr_neq_reg && !bus.hw_ptr_update) begin
                    // Host polled and caught up on its own: drop the pending
                    // interrupt entirely. This takes precedence over expiry.
                    state_next = ST_IDLE;
                    evcnt_next = '0;
                end else begin
                    evcnt_next = evcnt_inc;
                    if (bus.hst_rdy && (timer_exp || th_hit)) begin
                        state_next = ST_REQ;
                    end else if (bus.hst_rdy) begin
                        timer_next = timer_reg - TW'(1);
                    end
                end
            end

            ST_REQ: begin
                // Request is never retracted; only the core's accept ends it.
                evcnt_next = evcnt_inc;
                if (!bus.cfg_interrupt_rdy_n) begin
                    state_next     = ST_LOCKOUT;
                    irq_count_next = irq_count_reg + 32'd1;
                    sw_snap_next   = bus.sw_ptr;
                    evcnt_next     = '0;
`ifdef IRQ_LOCKOUT_TIMEOUT_EN
                    timer_next     = LOCKOUT_LOAD;
`endif
                end
            end

            ST_LOCKOUT: begin
                evcnt_next = evcnt_inc;
                if (sw_moved) begin
                    // Host acknowledged by writing back sw_ptr; re-arm only
                    // if there is still outstanding work.
                    if (ptr_neq_reg || (evcnt_inc != '0)) begin
                        state_next = ST_ARMED;
                        timer_next = HOLDOFF_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
`ifdef IRQ_LOCKOUT_TIMEOUT_EN
                else if (timer_exp && ptr_neq_reg) begin
                    // No write-back within the timeout while work is still
                    // outstanding: assume the interrupt was lost and re-fire.
                    state_next = ST_REQ;
                end else if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end
`endif
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            evcnt_reg       <= '0;
            sw_snap_reg     <= '0;
            irq_count_reg   <= '0;
            ptr_neq_reg     <= 1'b0;
            cfg_int_n_reg   <= 1'b1;
            irq_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            evcnt_reg       <= evcnt_next;
            sw_snap_reg     <= sw_snap_next;
            irq_count_reg   <= irq_count_next;
            // Full-width equality only; pointer wrap needs no handling.
            ptr_neq_reg     <= (bus.hw_ptr != bus.sw_ptr);
            // Output flops are loaded from the next state so they line up
            // with the state register without a combinational output path.
            cfg_int_n_reg   <= (state_next != ST_REQ);
            irq_pending_reg <= (state_next != ST_IDLE);
        end
    end

    assign bus.cfg_interrupt_n = cfg_int_n_reg;
    assign irq_pending         = irq_pending_reg;
    assign irq_count           = irq_count_reg;

endmodule
